// File: rtl/cpu_pkg.sv
// Shared constants for the MIPS pipeline: widths, architectural register
// indices and the write-back source encoding.
package cpu_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int REG_ZERO = 0;
    localparam int REG_RA   = 31;

    typedef enum logic [1:0] {
        WB_SEL_ALU  = 2'd0,
        WB_SEL_MEM  = 2'd1,
        WB_SEL_LINK = 2'd2
    } wb_sel_e;

    // Link address outranks the memory result, which outranks the ALU.
    function automatic wb_sel_e wb_sel_decode(input logic jump, input logic mem_reg);
        if (jump) begin
            return WB_SEL_LINK;
        end else if (mem_reg) begin
            return WB_SEL_MEM;
        end
        return WB_SEL_ALU;
    endfunction

endpackage

// File: rtl/wb_regfile_stage_if.sv
// MEM/WB-to-write-back bus plus the decode read ports and debug outputs.
// master = pipeline side driving the buffer outputs, slave = the stage.
interface wb_regfile_stage_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              inJump;
    logic              inRegW;
    logic              inMemReg;
    logic [DATA_W-1:0] inMemRes;
    logic [DATA_W-1:0] inALURes;
    logic [DATA_W-1:0] inJAddress;
    logic [ADDR_W-1:0] inRegMux;
    logic [ADDR_W-1:0] inRdAddrA;
    logic [ADDR_W-1:0] inRdAddrB;
    logic [DATA_W-1:0] outRdDataA;
    logic [DATA_W-1:0] outRdDataB;
    logic [DATA_W-1:0] outWbData;
    logic              outWbEn;
    logic [ADDR_W-1:0] outLastWbAddr;
    logic [DATA_W-1:0] outLastWbData;
    logic              outLastWbValid;
    logic [31:0]       outWbCount;

    modport master (
        output inJump, inRegW, inMemReg, inMemRes, inALURes, inJAddress,
               inRegMux, inRdAddrA, inRdAddrB,
        input  outRdDataA, outRdDataB, outWbData, outWbEn,
               outLastWbAddr, outLastWbData, outLastWbValid, outWbCount
    );

    modport slave (
        input  inJump, inRegW, inMemReg, inMemRes, inALURes, inJAddress,
               inRegMux, inRdAddrA, inRdAddrB,
        output outRdDataA, outRdDataB, outWbData, outWbEn,
               outLastWbAddr, outLastWbData, outLastWbValid, outWbCount
    );
endinterface

// File: rtl/regfile_2r1w.sv
// Register array with synchronous clear, one write port and two raw
// (unbypassed, unmasked) combinational read ports.
module regfile_2r1w #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_a_i,
    input  logic [ADDR_W-1:0] raddr_b_i,
    output logic [DATA_W-1:0] rdata_a_o,
    output logic [DATA_W-1:0] rdata_b_o
);
    localparam int NREGS = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [NREGS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/wb_regfile_stage.sv
// Write-back stage: selects the commit value, writes the register file and
// serves two bypassed read ports, plus last-commit and commit-count debug state.
module wb_regfile_stage #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    wb_regfile_stage_if.slave    bus
);
    import cpu_pkg::*;

    localparam int NPORTS = 2;

    wb_sel_e           wb_sel;
    logic [DATA_W-1:0] wb_data;
    logic              wb_en;

    logic [ADDR_W-1:0] rd_addr [NPORTS];
    logic [DATA_W-1:0] rd_raw  [NPORTS];
    logic [DATA_W-1:0] rd_data [NPORTS];

    logic [ADDR_W-1:0] last_addr_q,  last_addr_d;
    logic [DATA_W-1:0] last_data_q,  last_data_d;
    logic              last_valid_q, last_valid_d;
    logic [31:0]       wb_count_q,   wb_count_d;

    assign wb_sel = wb_sel_decode(bus.inJump, bus.inMemReg);

    always_comb begin
        wb_data = bus.inALURes;
        case (wb_sel)
            WB_SEL_LINK: wb_data = bus.inJAddress;
            WB_SEL_MEM:  wb_data = bus.inMemRes;
            default:     wb_data = bus.inALURes;
        endcase
    end

    // Gating with rst_n keeps a write presented during reset out of the bypass too.
    assign wb_en = bus.inRegW & (bus.inRegMux != ADDR_W'(REG_ZERO)) & rst_n;

    regfile_2r1w #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .we_i      (wb_en),
        .waddr_i   (bus.inRegMux),
        .wdata_i   (wb_data),
        .raddr_a_i (rd_addr[0]),
        .raddr_b_i (rd_addr[1]),
        .rdata_a_o (rd_raw[0]),
        .rdata_b_o (rd_raw[1])
    );

    assign rd_addr[0] = bus.inRdAddrA;
    assign rd_addr[1] = bus.inRdAddrB;

    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_read_port
        assign rd_data[gi] = (rd_addr[gi] == ADDR_W'(REG_ZERO))       ? '0      :
                             (wb_en && (rd_addr[gi] == bus.inRegMux)) ? wb_data :
                                                                        rd_raw[gi];
    end

    assign bus.outRdDataA = rd_data[0];
    assign bus.outRdDataB = rd_data[1];
    assign bus.outWbData  = wb_data;
    assign bus.outWbEn    = wb_en;

    always_comb begin
        last_valid_d = wb_en;
        last_addr_d  = last_addr_q;
        last_data_d  = last_data_q;
        wb_count_d   = wb_count_q;
        if (wb_en) begin
            last_addr_d = bus.inRegMux;
            last_data_d = wb_data;
            wb_count_d  = wb_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_valid_q <= 1'b0;
            last_addr_q  <= '0;
            last_data_q  <= '0;
            wb_count_q   <= '0;
        end else begin
            last_valid_q <= last_valid_d;
            last_addr_q  <= last_addr_d;
            last_data_q  <= last_data_d;
            wb_count_q   <= wb_count_d;
        end
    end

    assign bus.outLastWbValid = last_valid_q;
    assign bus.outLastWbAddr  = last_addr_q;
    assign bus.outLastWbData  = last_data_q;
    assign bus.outWbCount     = wb_count_q;

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Self-checking bench for wb_regfile_stage: directed scenarios plus a random
// stream checked against an array-based architectural model.
module tb_wb_regfile_stage;

    localparam int DW = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   compared = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    wb_regfile_stage_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    wb_regfile_stage #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Architectural model state
    logic [DW-1:0] m_regs [32];
    logic [31:0]   m_count;
    logic [AW-1:0] m_last_addr;
    logic [DW-1:0] m_last_data;
    logic          m_last_valid;

    function automatic logic [DW-1:0] model_wb();
        if (bus.inJump)   return bus.inJAddress;
        if (bus.inMemReg) return bus.inMemRes;
        return bus.inALURes;
    endfunction

    function automatic logic model_en();
        return bus.inRegW && (bus.inRegMux != 0) && rst_n;
    endfunction

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] idx);
        if (idx == 0) return '0;
        if (model_en() && idx == bus.inRegMux) return model_wb();
        return m_regs[idx];
    endfunction

    task automatic drive(input logic jump, input logic regw, input logic memreg,
                         input logic [DW-1:0] memres, input logic [DW-1:0] alures,
                         input logic [DW-1:0] jaddr, input logic [AW-1:0] mux);
        bus.inJump     = jump;
        bus.inRegW     = regw;
        bus.inMemReg   = memreg;
        bus.inMemRes   = memres;
        bus.inALURes   = alures;
        bus.inJAddress = jaddr;
        bus.inRegMux   = mux;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        bus.inRdAddrA = '0;
        bus.inRdAddrB = '0;
    endtask

    // Advance one clock edge and update the model with the presented write.
    task automatic step();
        logic [DW-1:0] wb;
        logic          en;
        wb = model_wb();
        en = model_en();
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_count      = '0;
            m_last_addr  = '0;
            m_last_data  = '0;
            m_last_valid = 1'b0;
        end else begin
            if (en) begin
                m_regs[bus.inRegMux] = wb;
                m_last_addr = bus.inRegMux;
                m_last_data = wb;
                m_count     = m_count + 32'd1;
            end
            m_last_valid = en;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        bus.inRegW = 1'b1;
        bus.inRegMux = 5'd3;
        bus.inALURes = 32'hAAAA_5555;
        #1;
        compared++;
        if (bus.outWbEn !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_wben: got %0b want 0", bus.outWbEn);
        end
        step();
        idle();
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) begin
            bus.inRdAddrA = AW'(i);
            bus.inRdAddrB = AW'(31 - i);
            #1;
            compared++;
            if (bus.outRdDataA !== 32'h0 || bus.outRdDataB !== 32'h0) begin
                mismatched++;
                $display("FAIL reset_read[%0d]: got A=%h B=%h want 0", i, bus.outRdDataA, bus.outRdDataB);
            end
        end
        compared++;
        if (bus.outWbCount !== 32'h0 || bus.outLastWbValid !== 1'b0 ||
            bus.outLastWbAddr !== '0 || bus.outLastWbData !== '0) begin
            mismatched++;
            $display("FAIL reset_state: got cnt=%h valid=%0b addr=%0d data=%h want all 0",
                     bus.outWbCount, bus.outLastWbValid, bus.outLastWbAddr, bus.outLastWbData);
        end
        $display("test_reset done");
    endtask

    task automatic test_alu_write();
        drive(1'b0, 1'b1, 1'b0, 32'h1111_1111, 32'h0000_1234, 32'h2222_2222, 5'd8);
        bus.inRdAddrA = 5'd8;
        bus.inRdAddrB = 5'd9;
        #1;
        compared++;
        if (bus.outRdDataA !== 32'h0000_1234 || bus.outWbEn !== 1'b1) begin
            mismatched++;
            $display("FAIL alu_bypass: got A=%h en=%0b want 00001234 en=1", bus.outRdDataA, bus.outWbEn);
        end
        compared++;
        if (bus.outRdDataB !== 32'h0) begin
            mismatched++;
            $display("FAIL alu_nobypass: got B=%h want 0", bus.outRdDataB);
        end
        step();
        idle();
        bus.inRdAddrA = 5'd8;
        #1;
        compared++;
        if (bus.outRdDataA !== 32'h0000_1234 || bus.outLastWbAddr !== 5'd8 ||
            bus.outLastWbData !== 32'h0000_1234 || bus.outLastWbValid !== 1'b1 ||
            bus.outWbCount !== 32'd1) begin
            mismatched++;
            $display("FAIL alu_commit: got r8=%h addr=%0d data=%h valid=%0b cnt=%0d want 1234/8/1234/1/1",
                     bus.outRdDataA, bus.outLastWbAddr, bus.outLastWbData, bus.outLastWbValid, bus.outWbCount);
        end
        step();
        compared++;
        if (bus.outLastWbValid !== 1'b0 || bus.outLastWbAddr !== 5'd8) begin
            mismatched++;
            $display("FAIL last_hold: got valid=%0b addr=%0d want 0/8", bus.outLastWbValid, bus.outLastWbAddr);
        end
        $display("test_alu_write done");
    endtask

    task automatic test_priority();
        drive(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 32'h0040_0008, 5'd31);
        #1;
        compared++;
        if (bus.outWbData !== 32'h0040_0008) begin
            mismatched++;
            $display("FAIL prio_link: got %h want 00400008", bus.outWbData);
        end
        step();
        drive(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 32'h0040_0008, 5'd20);
        bus.inRdAddrA = 5'd31;
        bus.inRdAddrB = 5'd20;
        #1;
        compared++;
        if (bus.outRdDataA !== 32'h0040_0008 || bus.outRdDataB !== 32'hDEAD_BEEF) begin
            mismatched++;
            $display("FAIL prio_mem: got r31=%h r20=%h want 00400008/deadbeef", bus.outRdDataA, bus.outRdDataB);
        end
        step();
        $display("test_priority done");
    endtask

    task automatic test_zero_reg();
        logic [31:0] cnt_before;
        cnt_before = m_count;
        drive(1'b0, 1'b1, 1'b0, '0, 32'hFFFF_FFFF, '0, 5'd0);
        bus.inRdAddrA = 5'd0;
        bus.inRdAddrB = 5'd0;
        #1;
        compared++;
        if (bus.outWbEn !== 1'b0 || bus.outRdDataA !== 32'h0 || bus.outRdDataB !== 32'h0) begin
            mismatched++;
            $display("FAIL zero_same: got en=%0b A=%h B=%h want 0/0/0", bus.outWbEn, bus.outRdDataA, bus.outRdDataB);
        end
        step();
        idle();
        #1;
        compared++;
        if (bus.outLastWbValid !== 1'b0 || bus.outWbCount !== cnt_before || bus.outRdDataA !== 32'h0) begin
            mismatched++;
            $display("FAIL zero_after: got valid=%0b cnt=%0d A=%h want 0/%0d/0",
                     bus.outLastWbValid, bus.outWbCount, bus.outRdDataA, cnt_before);
        end
        $display("test_zero_reg done");
    endtask

    task automatic test_reset_midstream();
        drive(1'b0, 1'b1, 1'b0, '0, 32'd7, '0, 5'd5);
        step();
        drive(1'b0, 1'b1, 1'b0, '0, 32'd9, '0, 5'd6);
        bus.inRdAddrA = 5'd6;
        rst_n = 1'b0;
        #1;
        compared++;
        if (bus.outWbEn !== 1'b0 || bus.outRdDataA !== 32'h0) begin
            mismatched++;
            $display("FAIL midrst_drop: got en=%0b r6=%h want 0/0", bus.outWbEn, bus.outRdDataA);
        end
        step();
        rst_n = 1'b1;
        idle();
        bus.inRdAddrA = 5'd5;
        bus.inRdAddrB = 5'd6;
        #1;
        compared++;
        if (bus.outRdDataA !== 32'h0 || bus.outRdDataB !== 32'h0 || bus.outWbCount !== 32'h0) begin
            mismatched++;
            $display("FAIL midrst_clear: got r5=%h r6=%h cnt=%0d want 0/0/0",
                     bus.outRdDataA, bus.outRdDataB, bus.outWbCount);
        end
        $display("test_reset_midstream done");
    endtask

    task automatic test_random();
        logic [AW-1:0] mux;
        for (int n = 0; n < 300; n++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            mux = AW'($urandom_range(0, 31));
            drive(1'(($urandom_range(0, 3) == 0)), 1'(($urandom_range(0, 3) != 0)),
                  1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, mux);
            bus.inRdAddrA = ($urandom_range(0, 2) == 0) ? mux : AW'($urandom_range(0, 31));
            bus.inRdAddrB = ($urandom_range(0, 4) == 0) ? bus.inRdAddrA : AW'($urandom_range(0, 31));
            #1;
            compared++;
            if (bus.outRdDataA !== model_read(bus.inRdAddrA) || bus.outRdDataB !== model_read(bus.inRdAddrB)) begin
                mismatched++;
                $display("FAIL rand_read[%0d]: got A[%0d]=%h B[%0d]=%h want %h/%h", n,
                         bus.inRdAddrA, bus.outRdDataA, bus.inRdAddrB, bus.outRdDataB,
                         model_read(bus.inRdAddrA), model_read(bus.inRdAddrB));
            end
            compared++;
            if (bus.outWbData !== model_wb() || bus.outWbEn !== model_en()) begin
                mismatched++;
                $display("FAIL rand_wb[%0d]: got data=%h en=%0b want %h/%0b", n,
                         bus.outWbData, bus.outWbEn, model_wb(), model_en());
            end
            compared++;
            if (bus.outLastWbValid !== m_last_valid || bus.outLastWbAddr !== m_last_addr ||
                bus.outLastWbData !== m_last_data || bus.outWbCount !== m_count) begin
                mismatched++;
                $display("FAIL rand_state[%0d]: got v=%0b a=%0d d=%h c=%0d want %0b/%0d/%h/%0d", n,
                         bus.outLastWbValid, bus.outLastWbAddr, bus.outLastWbData, bus.outWbCount,
                         m_last_valid, m_last_addr, m_last_data, m_count);
            end
            step();
        end
        rst_n = 1'b1;
        $display("test_random done");
    endtask

    task automatic test_counter_wrap();
        idle();
        force dut.wb_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.wb_count_q;
        m_count = 32'hFFFF_FFFF;
        #1;
        compared++;
        if (bus.outWbCount !== 32'hFFFF_FFFF) begin
            mismatched++;
            $display("FAIL wrap_preload: got %h want ffffffff", bus.outWbCount);
        end
        drive(1'b0, 1'b1, 1'b0, '0, 32'h55, '0, 5'd12);
        step();
        idle();
        #1;
        compared++;
        if (bus.outWbCount !== 32'h0 || bus.outWbCount !== m_count) begin
            mismatched++;
            $display("FAIL wrap: got %h want 0", bus.outWbCount);
        end
        $display("test_counter_wrap done");
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_alu_write();
        test_priority();
        test_zero_reg();
        test_reset_midstream();
        test_random();
        test_counter_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/wb_regfile_stage.md
# wb_regfile_stage

Write-back stage and architectural register file of the five-stage MIPS pipeline. Consumes the registered MEM/WB pipeline-buffer outputs, selects the write-back value, and commits it to a 32×32 register file. Serves the two combinational read ports of the decode stage, with same-cycle write-through bypass. Also provides a one-cycle-delayed copy of the last commit for the forwarding unit, and a retired-write counter for debug.

## Interface
Parameters:
- DATA_W, 32, register and data width
- ADDR_W, 5, register index width (2^ADDR_W registers)

Ports:
- clk  in  1  pipeline clock, all state updates on rising edge
- rst_n  in  1  synchronous reset, active-low
- inJump  in  1  write-back value is the link address (jal-type)
- inRegW  in  1  register write enable from MEM/WB buffer
- inMemReg  in  1  write-back value is the memory result
- inMemRes  in  DATA_W  data-memory read result
- inALURes  in  DATA_W  ALU result
- inJAddress  in  DATA_W  link address (PC+4, computed upstream)
- inRegMux  in  ADDR_W  destination register index
- inRdAddrA, inRdAddrB  in  ADDR_W  decode-stage read indices
- outRdDataA, outRdDataB  out  DATA_W  read data, combinational
- outWbData  out  DATA_W  selected write-back value, combinational
- outWbEn  out  1  effective write enable, combinational
- outLastWbAddr  out  ADDR_W  index of the previous cycle's commit
- outLastWbData  out  DATA_W  data of the previous cycle's commit
- outLastWbValid  out  1  a commit occurred in the previous cycle
- outWbCount  out  32  number of committed writes since reset

## Operation
- Write-back select, priority order: inJump=1 → inJAddress; else inMemReg=1 → inMemRes; else inALURes.
- outWbEn = inRegW & (inRegMux != 0) & rst_n. Register 0 is never written and always reads 0.
- Commit: on the rising edge with outWbEn=1, reg[inRegMux] ← outWbData.
- Read port X (A or B):
  - index 0 → 0.
  - else if outWbEn and index == inRegMux → outWbData (bypass).
  - else → reg[index].
- Last-commit registers, every edge:
  - outLastWbValid ← outWbEn.
  - When outWbEn=1, outLastWbAddr ← inRegMux and outLastWbData ← outWbData; otherwise both hold.
- outWbCount increments by 1 per commit and wraps from 0xFFFFFFFF to 0.
- No state machine; the stage is the register array plus the last-commit and counter registers.

## Timing
- Write latency: 1 edge. A value committed at edge N is readable from the array after edge N, and via bypass during the cycle before edge N.
- Read latency: 0 (combinational from indices and array).
- Reset, rst_n=0 sampled at a rising edge:
  - all 32 registers cleared to 0.
  - outLastWbValid=0, outLastWbAddr=0, outLastWbData=0, outWbCount=0.
  - any write presented in that cycle is dropped, and outWbEn is 0 while rst_n=0.
- Reset asserted mid-stream discards the in-flight write. The first commit can occur at the first edge with rst_n=1.
- Simultaneous reads of the same index on A and B both see identical data, including the bypass.
- inRegW=1 with inRegMux=0: no commit, counter unchanged, outLastWbValid ← 0.
- Before the first reset, contents are undefined. The bench must reset before checking.

## Structure
- Shared package (cpu_pkg): DATA_W, ADDR_W, REG_ZERO=0, REG_RA=31, and write-back select encoding constants.
- One sub-module: regfile_2r1w (array, reset clear, write port, two raw read ports).
- The top level adds the select mux, bypass, zero masking, last-commit registers and counter.

## Test plan
- Reset then read all indices: rst_n=0 for one edge → every outRdData=0, outWbCount=0, outLastWbValid=0.
- ALU write: inRegW=1, inMemReg=0, inALURes=0x0000_1234, inRegMux=8.
  - Same cycle: inRdAddrA=8 → 0x1234 (bypass).
  - After the edge: reg8=0x1234, outLastWbAddr=8, outLastWbValid=1, outWbCount=1.
- Select priority: inJump=1, inMemReg=1, inJAddress=0x0040_0008, inMemRes=0xDEAD_BEEF, inRegMux=31 → reg31=0x0040_0008.
- Zero register: inRegW=1, inRegMux=0, inALURes=0xFFFF_FFFF → reads of 0 stay 0, count unchanged, outLastWbValid=0 next cycle.
- Reset mid-operation:
  - Write reg5=7, then rst_n=0 in the same cycle as a write of reg6=9.
  - Result: reg5=0, reg6=0, count=0.
- Counter wrap: force 0xFFFF_FFFF commits (or preload via hierarchical force), one more commit → outWbCount=0.
